// File: rtl/pbus_decoder_tmo_if.sv
// -----------------------------------------------------------------------------
// pbus_decoder_tmo_if
// Master-side Wishbone bundle of the peripheral-bus decoder.
//   WB_ADRi / WB_DATi / WB_WEi / WB_CYCi / WB_STBi : request from the bus master
//   WB_DATo / WB_ACKo / WB_ERRo                    : response back to the master
// The "master" modport is the bus master's view; "slave" is the decoder's view.
// -----------------------------------------------------------------------------
interface pbus_decoder_tmo_if #(
    parameter int AW = 12,
    parameter int DW = 8
);
    logic [AW-1:0] WB_ADRi;
    logic [DW-1:0] WB_DATi;
    logic [DW-1:0] WB_DATo;
    logic          WB_WEi;
    logic          WB_CYCi;
    logic          WB_STBi;
    logic          WB_ACKo;
    logic          WB_ERRo;

    modport master (
        output WB_ADRi, WB_DATi, WB_WEi, WB_CYCi, WB_STBi,
        input  WB_DATo, WB_ACKo, WB_ERRo
    );

    modport slave (
        input  WB_ADRi, WB_DATi, WB_WEi, WB_CYCi, WB_STBi,
        output WB_DATo, WB_ACKo, WB_ERRo
    );
endinterface

// File: rtl/pbus_decoder_tmo.sv
// -----------------------------------------------------------------------------
// pbus_decoder_tmo
// Wishbone peripheral-bus decoder with per-access timeout and bus-error capture.
// A byte-wide master port is routed to NS slave windows (base/mask compare,
// lowest index wins on overlap). Read data is registered on the way back.
// Unmapped or timed-out accesses end with WB_ERRo; the first faulting address
// and its cause are held for the interrupt controller until BERR_CLR.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   wb           : master-side Wishbone bundle (decoder view)
//   S_ADRo/S_DATo/S_WEo : latched address/write data/write enable to slaves
//   S_CYCo       : high while an access is in progress
//   S_STBo[NS]   : one-hot slave strobe
//   S_ACKi[NS]   : per-slave acknowledge
//   S_DATi       : packed per-slave read data, slave i at [i*DW +: DW]
//   BERR_INT/ADDR/CAUSE/OVF : bus-error capture (cause 01 miss, 10 timeout)
//   BERR_CLR     : clears INT, CAUSE and OVF (ADDR holds)
// -----------------------------------------------------------------------------
module pbus_decoder_tmo #(
    parameter int               AW       = 12,
    parameter int               DW       = 8,
    parameter int               NS       = 5,
    parameter logic [NS*AW-1:0] SLV_BASE = '0,
    parameter logic [NS*AW-1:0] SLV_MASK = '0,
    parameter int               TIMEOUT  = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    pbus_decoder_tmo_if.slave    wb,
    output logic [AW-1:0]        S_ADRo,
    output logic [DW-1:0]        S_DATo,
    output logic                 S_WEo,
    output logic                 S_CYCo,
    output logic [NS-1:0]        S_STBo,
    input  logic [NS-1:0]        S_ACKi,
    input  logic [NS*DW-1:0]     S_DATi,
    output logic                 BERR_INT,
    output logic [AW-1:0]        BERR_ADDR,
    output logic [1:0]           BERR_CAUSE,
    output logic                 BERR_OVF,
    input  logic                 BERR_CLR
);

    localparam int             CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [1:0]     CAUSE_MISS = 2'b01;
    localparam logic [1:0]     CAUSE_TMO  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP,
        ST_ERR
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  adr_q, adr_d;
    logic [DW-1:0]  dat_q, dat_d;
    logic           we_q, we_d;
    logic [NS-1:0]  sel_q, sel_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]  rdat_q, rdat_d;
    logic           berr_int_q, berr_int_d;
    logic [AW-1:0]  berr_addr_q, berr_addr_d;
    logic [1:0]     berr_cause_q, berr_cause_d;
    logic           berr_ovf_q, berr_ovf_d;

    logic [NS-1:0]  hit;
    logic [NS-1:0]  sel_first;
    logic           ack_sel;
    logic [DW-1:0]  rdat_mux;
    logic           err_now;
    logic [1:0]     err_cause;
    logic [AW-1:0]  err_addr;

    // Address decode: a window hits when every masked bit matches its base.
    generate
        for (genvar gi = 0; gi < NS; gi++) begin : g_hit
            assign hit[gi] = ((wb.WB_ADRi ^ SLV_BASE[gi*AW +: AW])
                              & SLV_MASK[gi*AW +: AW]) == '0;
        end
    endgenerate

    // Isolate the lowest set bit so overlapping windows resolve to the lowest index.
    assign sel_first = hit & (~hit + NS'(1));

    // Only the selected slave's ack counts; others are masked off.
    assign ack_sel = |(S_ACKi & sel_q);

    always_comb begin
        rdat_mux = '0;
        for (int i = 0; i < NS; i++) begin
            if (sel_q[i]) begin
                rdat_mux = S_DATi[i*DW +: DW];
            end
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        we_d      = we_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        rdat_d    = rdat_q;
        err_now   = 1'b0;
        err_cause = 2'b00;
        err_addr  = adr_q;

        case (state_q)
            ST_IDLE: begin
                if (wb.WB_CYCi && wb.WB_STBi) begin
                    if (|hit) begin
                        adr_d   = wb.WB_ADRi;
                        dat_d   = wb.WB_DATi;
                        we_d    = wb.WB_WEi;
                        sel_d   = sel_first;
                        cnt_d   = '0;
                        state_d = ST_ACCESS;
                    end else begin
                        err_now   = 1'b1;
                        err_cause = CAUSE_MISS;
                        err_addr  = wb.WB_ADRi;
                        state_d   = ST_ERR;
                    end
                end
            end
            ST_ACCESS: begin
                // Saturating count of ACCESS cycles.
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (!wb.WB_CYCi) begin
                    // Master abandoned the cycle: leave quietly.
                    state_d = ST_IDLE;
                end else if (ack_sel) begin
                    // Ack takes priority over a simultaneous timeout.
                    if (!we_q) begin
                        rdat_d = rdat_mux;
                    end
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    err_now   = 1'b1;
                    err_cause = CAUSE_TMO;
                    err_addr  = adr_q;
                    state_d   = ST_ERR;
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Error capture: the first error wins; later ones only flag overflow.
    // A clear arriving with a new error makes that error the new "first".
    always_comb begin
        berr_int_d   = berr_int_q;
        berr_addr_d  = berr_addr_q;
        berr_cause_d = berr_cause_q;
        berr_ovf_d   = berr_ovf_q;
        if (err_now) begin
            if (!berr_int_q || BERR_CLR) begin
                berr_int_d   = 1'b1;
                berr_addr_d  = err_addr;
                berr_cause_d = err_cause;
                berr_ovf_d   = 1'b0;
            end else begin
                berr_ovf_d   = 1'b1;
            end
        end else if (BERR_CLR) begin
            berr_int_d   = 1'b0;
            berr_cause_d = 2'b00;
            berr_ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            adr_q        <= '0;
            dat_q        <= '0;
            we_q         <= 1'b0;
            sel_q        <= '0;
            cnt_q        <= '0;
            rdat_q       <= '0;
            berr_int_q   <= 1'b0;
            berr_addr_q  <= '0;
            berr_cause_q <= 2'b00;
            berr_ovf_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            we_q         <= we_d;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            rdat_q       <= rdat_d;
            berr_int_q   <= berr_int_d;
            berr_addr_q  <= berr_addr_d;
            berr_cause_q <= berr_cause_d;
            berr_ovf_q   <= berr_ovf_d;
        end
    end

    assign wb.WB_DATo = rdat_q;
    assign wb.WB_ACKo = (state_q == ST_RESP);
    assign wb.WB_ERRo = (state_q == ST_ERR);
    assign S_ADRo     = adr_q;
    assign S_DATo     = dat_q;
    assign S_WEo      = we_q;
    assign S_CYCo     = (state_q == ST_ACCESS);
    assign S_STBo     = (state_q == ST_ACCESS) ? sel_q : '0;
    assign BERR_INT   = berr_int_q;
    assign BERR_ADDR  = berr_addr_q;
    assign BERR_CAUSE = berr_cause_q;
    assign BERR_OVF   = berr_ovf_q;

endmodule

// File: tb/tb_pbus_decoder_tmo.sv
// -----------------------------------------------------------------------------
// tb_pbus_decoder_tmo
// Two decoders share one master and one set of slave responses: instance 0 uses
// the reference window map, instance 1 widens slave 2's mask so that it
// overlaps slave 1. Both must behave identically on every transaction, which
// exercises lowest-index priority. Transactions come from a vector table;
// abort and mid-access reset are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_pbus_decoder_tmo;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int NS = 5;
    localparam logic [NS*AW-1:0] BASE  = {12'h800, 12'h700, 12'h6F8, 12'h6F0, 12'h600};
    localparam logic [NS*AW-1:0] MASK0 = {12'h800, 12'hF00, 12'hFF8, 12'hFF8, 12'hFFC};
    localparam logic [NS*AW-1:0] MASK1 = {12'h800, 12'hF00, 12'hFF0, 12'hFF8, 12'hFFC};

    logic clk = 1'b0;
    logic rst;
    logic [NS-1:0]    s_acki;
    logic [NS*DW-1:0] s_dati;
    logic             berr_clr;

    logic [AW-1:0] s_adr [2];
    logic [DW-1:0] s_dat [2];
    logic          s_we  [2];
    logic          s_cyc [2];
    logic [NS-1:0] s_stb [2];
    logic          b_int [2];
    logic [AW-1:0] b_addr[2];
    logic [1:0]    b_cause[2];
    logic          b_ovf [2];
    logic          ack   [2];
    logic          err   [2];
    logic [DW-1:0] dato  [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pbus_decoder_tmo_if #(.AW(AW), .DW(DW)) wb0 ();
    pbus_decoder_tmo_if #(.AW(AW), .DW(DW)) wb1 ();

    assign wb1.WB_ADRi = wb0.WB_ADRi;
    assign wb1.WB_DATi = wb0.WB_DATi;
    assign wb1.WB_WEi  = wb0.WB_WEi;
    assign wb1.WB_CYCi = wb0.WB_CYCi;
    assign wb1.WB_STBi = wb0.WB_STBi;
    assign ack[0]  = wb0.WB_ACKo;
    assign err[0]  = wb0.WB_ERRo;
    assign dato[0] = wb0.WB_DATo;
    assign ack[1]  = wb1.WB_ACKo;
    assign err[1]  = wb1.WB_ERRo;
    assign dato[1] = wb1.WB_DATo;

    pbus_decoder_tmo #(.AW(AW), .DW(DW), .NS(NS), .SLV_BASE(BASE), .SLV_MASK(MASK0), .TIMEOUT(15)) dut0 (
        .clk(clk), .rst(rst), .wb(wb0.slave),
        .S_ADRo(s_adr[0]), .S_DATo(s_dat[0]), .S_WEo(s_we[0]), .S_CYCo(s_cyc[0]),
        .S_STBo(s_stb[0]), .S_ACKi(s_acki), .S_DATi(s_dati),
        .BERR_INT(b_int[0]), .BERR_ADDR(b_addr[0]), .BERR_CAUSE(b_cause[0]),
        .BERR_OVF(b_ovf[0]), .BERR_CLR(berr_clr)
    );

    pbus_decoder_tmo #(.AW(AW), .DW(DW), .NS(NS), .SLV_BASE(BASE), .SLV_MASK(MASK1), .TIMEOUT(15)) dut1 (
        .clk(clk), .rst(rst), .wb(wb1.slave),
        .S_ADRo(s_adr[1]), .S_DATo(s_dat[1]), .S_WEo(s_we[1]), .S_CYCo(s_cyc[1]),
        .S_STBo(s_stb[1]), .S_ACKi(s_acki), .S_DATi(s_dati),
        .BERR_INT(b_int[1]), .BERR_ADDR(b_addr[1]), .BERR_CAUSE(b_cause[1]),
        .BERR_OVF(b_ovf[1]), .BERR_CLR(berr_clr)
    );

    typedef struct {
        string       name;
        logic [11:0] adr;
        logic [7:0]  dat;
        logic        we;
        int          ack_slv;   // -1: no slave acks
        int          ack_wait;  // ACCESS cycles before the ack appears
        logic [7:0]  rdata;
        logic        clr;       // BERR_CLR together with the request
        logic [4:0]  exp_stb;
        logic        exp_err;
        int          exp_lat;   // cycle (after request edge) of ACK/ERR
        logic [7:0]  exp_dato;
        logic        exp_int;
        logic [11:0] exp_addr;
        logic [1:0]  exp_cause;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_d%0d_ack", tag, d),   ack[d],     0);
            chk($sformatf("%s_d%0d_err", tag, d),   err[d],     0);
            chk($sformatf("%s_d%0d_dato", tag, d),  dato[d],    0);
            chk($sformatf("%s_d%0d_sadr", tag, d),  s_adr[d],   0);
            chk($sformatf("%s_d%0d_sdat", tag, d),  s_dat[d],   0);
            chk($sformatf("%s_d%0d_swe", tag, d),   s_we[d],    0);
            chk($sformatf("%s_d%0d_scyc", tag, d),  s_cyc[d],   0);
            chk($sformatf("%s_d%0d_sstb", tag, d),  s_stb[d],   0);
            chk($sformatf("%s_d%0d_bint", tag, d),  b_int[d],   0);
            chk($sformatf("%s_d%0d_baddr", tag, d), b_addr[d],  0);
            chk($sformatf("%s_d%0d_bcause", tag, d), b_cause[d], 0);
            chk($sformatf("%s_d%0d_bovf", tag, d),  b_ovf[d],   0);
        end
    endtask

    task automatic run_txn(input vec_t v);
        int cyc_n;
        wb0.WB_ADRi = v.adr;
        wb0.WB_DATi = v.dat;
        wb0.WB_WEi  = v.we;
        wb0.WB_CYCi = 1'b1;
        wb0.WB_STBi = 1'b1;
        berr_clr    = v.clr;
        tick();
        berr_clr = 1'b0;
        cyc_n = 1;
        while (cyc_n <= 40 && !(ack[0] || err[0])) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("%s_d%0d_c%0d_stb", v.name, d, cyc_n), s_stb[d], v.exp_stb);
                chk($sformatf("%s_d%0d_c%0d_scyc", v.name, d, cyc_n), s_cyc[d], (v.exp_stb != 0));
                if (v.exp_stb != 0) begin
                    chk($sformatf("%s_d%0d_c%0d_sadr", v.name, d, cyc_n), s_adr[d], v.adr);
                    chk($sformatf("%s_d%0d_c%0d_swe", v.name, d, cyc_n), s_we[d], v.we);
                    if (v.we) chk($sformatf("%s_d%0d_c%0d_sdat", v.name, d, cyc_n), s_dat[d], v.dat);
                end
            end
            s_acki = '0;
            s_dati = 40'hA1B2C3D4E5;
            if (v.ack_slv >= 0 && cyc_n >= v.ack_wait + 1) begin
                s_acki[v.ack_slv] = 1'b1;
                s_dati[v.ack_slv*DW +: DW] = v.rdata;
            end
            tick();
            cyc_n++;
        end
        chk($sformatf("%s_latency", v.name), cyc_n, v.exp_lat);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_d%0d_ack", v.name, d),  ack[d],  !v.exp_err);
            chk($sformatf("%s_d%0d_err", v.name, d),  err[d],  v.exp_err);
            chk($sformatf("%s_d%0d_dato", v.name, d), dato[d], v.exp_dato);
        end
        wb0.WB_CYCi = 1'b0;
        wb0.WB_STBi = 1'b0;
        s_acki = '0;
        tick();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_d%0d_ack_1cyc", v.name, d), ack[d], 0);
            chk($sformatf("%s_d%0d_err_1cyc", v.name, d), err[d], 0);
            chk($sformatf("%s_d%0d_bint", v.name, d),   b_int[d],   v.exp_int);
            chk($sformatf("%s_d%0d_baddr", v.name, d),  b_addr[d],  v.exp_addr);
            chk($sformatf("%s_d%0d_bcause", v.name, d), b_cause[d], v.exp_cause);
            chk($sformatf("%s_d%0d_bovf", v.name, d),   b_ovf[d],   v.exp_ovf);
        end
        $display("txn %s adr=%h we=%0d lat=%0d ack=%0d err=%0d dato=%h berr=%0d/%h/%0d/%0d",
                 v.name, v.adr, v.we, cyc_n, ack[0], err[0], dato[0],
                 b_int[0], b_addr[0], b_cause[0], b_ovf[0]);
    endtask

    initial begin
        //           name        adr     dat    we  slv wt  rdata  clr  stb       err lat dato   int addr    cause ovf
        vecs[0] = '{"rd_6F3",   12'h6F3, 8'h00, 0,  1, 0, 8'h5A, 0, 5'b00010, 0,  2, 8'h5A, 0, 12'h000, 2'b00, 0};
        vecs[1] = '{"wr_9AB",   12'h9AB, 8'h3C, 1,  4, 3, 8'hEE, 0, 5'b10000, 0,  5, 8'h5A, 0, 12'h000, 2'b00, 0};
        vecs[2] = '{"miss_123", 12'h123, 8'h00, 0, -1, 0, 8'h00, 0, 5'b00000, 1,  1, 8'h5A, 1, 12'h123, 2'b01, 0};
        vecs[3] = '{"tmo_600",  12'h600, 8'h00, 0, -1, 0, 8'h00, 0, 5'b00001, 1, 16, 8'h5A, 1, 12'h123, 2'b01, 1};
        vecs[4] = '{"miss_050", 12'h050, 8'h00, 0, -1, 0, 8'h00, 1, 5'b00000, 1,  1, 8'h5A, 1, 12'h050, 2'b01, 0};
        vecs[5] = '{"ovl_6F4",  12'h6F4, 8'h00, 0,  2, 0, 8'h99, 1, 5'b00010, 1, 16, 8'h5A, 1, 12'h6F4, 2'b10, 0};
        vecs[6] = '{"rd_6FC",   12'h6FC, 8'h00, 0,  2, 1, 8'hC3, 0, 5'b00100, 0,  3, 8'hC3, 1, 12'h6F4, 2'b10, 0};
        vecs[7] = '{"rd_7A5",   12'h7A5, 8'h00, 0,  3, 0, 8'h81, 0, 5'b01000, 0,  2, 8'h81, 1, 12'h6F4, 2'b10, 0};

        rst = 1'b1;
        s_acki = '0;
        s_dati = '0;
        berr_clr = 1'b0;
        wb0.WB_ADRi = '0;
        wb0.WB_DATi = '0;
        wb0.WB_WEi  = 1'b0;
        wb0.WB_CYCi = 1'b0;
        wb0.WB_STBi = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        // BERR_CLR on its own: INT/CAUSE/OVF clear, address holds.
        berr_clr = 1'b1;
        tick();
        berr_clr = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("clr_d%0d_bint", d),   b_int[d],   0);
            chk($sformatf("clr_d%0d_bcause", d), b_cause[d], 0);
            chk($sformatf("clr_d%0d_bovf", d),   b_ovf[d],   0);
            chk($sformatf("clr_d%0d_baddr", d),  b_addr[d],  12'h6F4);
        end
        $display("txn berr_clr int=%0d addr=%h cause=%h ovf=%0d", b_int[0], b_addr[0], b_cause[0], b_ovf[0]);

        // Master drops CYC in the second ACCESS cycle.
        wb0.WB_ADRi = 12'h600;
        wb0.WB_WEi  = 1'b0;
        wb0.WB_CYCi = 1'b1;
        wb0.WB_STBi = 1'b1;
        tick();
        for (int d = 0; d < 2; d++) chk($sformatf("abort_d%0d_stb_c1", d), s_stb[d], 5'b00001);
        tick();
        for (int d = 0; d < 2; d++) chk($sformatf("abort_d%0d_stb_c2", d), s_stb[d], 5'b00001);
        wb0.WB_CYCi = 1'b0;
        wb0.WB_STBi = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("abort_d%0d_stb_k%0d", d, k),  s_stb[d], 0);
                chk($sformatf("abort_d%0d_scyc_k%0d", d, k), s_cyc[d], 0);
                chk($sformatf("abort_d%0d_ack_k%0d", d, k),  ack[d],   0);
                chk($sformatf("abort_d%0d_err_k%0d", d, k),  err[d],   0);
            end
        end
        $display("txn abort_600 stb=%b ack=%0d err=%0d", s_stb[0], ack[0], err[0]);

        // Retry, then reset in the second ACCESS cycle.
        wb0.WB_CYCi = 1'b1;
        wb0.WB_STBi = 1'b1;
        tick();
        for (int d = 0; d < 2; d++) chk($sformatf("rstmid_d%0d_stb_c1", d), s_stb[d], 5'b00001);
        rst = 1'b1;
        tick();
        chk_all_zero("rstmid");
        rst = 1'b0;
        wb0.WB_CYCi = 1'b0;
        wb0.WB_STBi = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rstmid_d%0d_ack_after", d), ack[d],   0);
            chk($sformatf("rstmid_d%0d_err_after", d), err[d],   0);
            chk($sformatf("rstmid_d%0d_stb_after", d), s_stb[d], 0);
        end
        $display("txn rst_mid_access stb=%b ack=%0d err=%0d bint=%0d", s_stb[0], ack[0], err[0], b_int[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pbus_decoder_tmo.md
Name: pbus_decoder_tmo

Overview:
- Parametrised Wishbone peripheral-bus decoder: the next generation of the fixed on-chip config/SPM decoder.
- Routes one byte-wide master port to NS slave windows defined by base/mask parameters, with lowest-index priority on overlap.
- Registers the read-data return and adds a per-access timeout.
- Unmapped or timed-out accesses terminate with WB_ERRo instead of returning undefined data. The faulting address and cause are captured and raised as an interrupt source for the interrupt controller.

Parameters:
AW, 12, address width of master and slave ports
DW, 8, data width
NS, 5, number of slave windows (1..16)
SLV_BASE, {NS*AW}'0, packed per-slave base addresses; slave i at bits [i*AW +: AW]
SLV_MASK, {NS*AW}'0, packed per-slave compare masks; a 1 bit is compared
TIMEOUT, 15, ACCESS cycles without ack before bus error (1..255)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
WB_ADRi  in  AW  master address
WB_DATi  in  DW  master write data
WB_DATo  out  DW  registered read data
WB_WEi  in  1  write enable
WB_CYCi  in  1  cycle valid
WB_STBi  in  1  strobe
WB_ACKo  out  1  access complete
WB_ERRo  out  1  access failed
S_ADRo  out  AW  shared slave address (latched)
S_DATo  out  DW  shared slave write data (latched)
S_WEo  out  1  shared write enable (latched)
S_CYCo  out  1  high while in ACCESS
S_STBo  out  NS  one-hot slave strobe
S_ACKi  in  NS  per-slave ack
S_DATi  in  NS*DW  packed per-slave read data
BERR_INT  out  1  sticky bus-error interrupt
BERR_ADDR  out  AW  address of first unserviced error
BERR_CAUSE  out  2  01 = decode miss, 10 = timeout
BERR_OVF  out  1  further error while BERR_INT pending
BERR_CLR  in  1  clears BERR_INT, BERR_CAUSE and BERR_OVF

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: FSM to IDLE. All outputs are 0: WB_DATo, WB_ACKo, WB_ERRo, S_*o, BERR_*. The timeout counter is cleared. Reset mid-access abandons the access with no ACK/ERR.
- Decode (combinational on WB_ADRi): hit[i] = ((WB_ADRi ^ base_i) & mask_i) == 0. The selected slave is the lowest i with hit[i]=1.
- FSM states: IDLE, ACCESS, RESP, ERR.
- IDLE: when CYC&STB are sampled high:
  - On a hit: latch ADR/DAT/WE and sel, clear the counter, go to ACCESS.
  - On a miss: latch the address, record cause 01, go to ERR.
- ACCESS: S_CYCo=1, S_STBo[sel]=1, counter increments each cycle.
  - S_ACKi[sel]=1: capture S_DATi[sel] into WB_DATo (reads only; writes hold the previous value), go to RESP.
  - Otherwise, counter == TIMEOUT-1: record cause 10, go to ERR.
  - ACK and timeout in the same cycle: ACK wins.
  - S_ACKi bits of non-selected slaves are ignored.
  - WB_CYCi low in ACCESS: abort to IDLE, with strobes low in the next cycle and no ACK/ERR.
- RESP: WB_ACKo=1 for exactly one cycle, then IDLE.
- ERR: WB_ERRo=1 for exactly one cycle, then IDLE.
- Master requirement: drop STB after the ACK/ERR edge. IDLE only accepts a fresh CYC&STB.
- Latency: request sampled at edge 0; S_STBo high in cycle 1. With S_ACKi in cycle 1, WB_ACKo is high in cycle 2. Decode miss gives WB_ERRo in cycle 1. Timeout gives WB_ERRo in cycle TIMEOUT+1.
- Error capture:
  - On entry to ERR with BERR_INT=0: load BERR_ADDR and BERR_CAUSE, set BERR_INT.
  - On entry to ERR with BERR_INT=1: keep the first address/cause, set BERR_OVF.
  - BERR_CLR alone: clears INT/CAUSE/OVF. BERR_ADDR holds.
  - BERR_CLR in the same cycle as a new error: the new error is captured, INT=1, OVF=0.
- Widths: the counter is clog2(TIMEOUT+1) bits and saturates (never wraps).

Test Plan:
- NS=5, base/mask mapping 0x600/0xFFC, 0x6F0/0xFF8, 0x6F8/0xFF8, 0x700/0xF00, 0x800/0x800. Read 0x6F3; slave1 acks in cycle 1 with 0x5A -> S_STBo=00010 in cycle 1, WB_ACKo and WB_DATo=0x5A in cycle 2.
- Write 0x9AB data 0x3C; slave4 acks after 3 wait cycles -> S_DATo=0x3C and S_WEo=1 throughout ACCESS, single-cycle WB_ACKo, WB_DATo unchanged.
- Read unmapped 0x123 -> WB_ERRo in cycle 1, no S_STBo, BERR_INT=1, BERR_ADDR=0x123, CAUSE=01.
- Slave 0 never acks at 0x600, TIMEOUT=15 -> WB_ERRo in cycle 16. Because BERR_INT is still pending, BERR_OVF=1 and BERR_ADDR stays 0x123. Then BERR_CLR in the same cycle as the next miss at 0x050 -> BERR_ADDR=0x050, OVF=0, INT=1.
- Overlap: slave2 mask widened to cover 0x6F0 -> access to 0x6F4 strobes slave1 only. S_ACKi[2] asserted by itself is ignored, so a timeout occurs.
- WB_CYCi dropped in 2nd ACCESS cycle, then rst pulsed mid-access on a retry -> no ACK/ERR, S_STBo=0 next cycle, all outputs 0 after rst.
